// File: rtl/disp_src_sel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_pkg : shared types and defaults for the display-source selector  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package disp_pkg;

    typedef enum logic [1:0] {
        LIVE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_HOUR = 2'd1;
    localparam logic [1:0] FLD_MIN  = 2'd2;
    localparam logic [1:0] FLD_SEC  = 2'd3;

    localparam int DEF_HW = 5;
    localparam int DEF_MW = 6;
    localparam int DEF_SW = 6;

endpackage
`default_nettype wire

// File: rtl/disp_src_sel_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_src_sel_if : source-select request/data bus and display outputs  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface disp_src_sel_if
    import disp_pkg::*;
#(
    parameter int NCH = 3,
    parameter int HW  = DEF_HW,
    parameter int MW  = DEF_MW,
    parameter int SW  = DEF_SW
);
    logic                     tick;
    logic [NCH-1:0]           req;
    logic [1:0]               edit_field;
    logic [NCH*HW-1:0]        hour_in;
    logic [NCH*MW-1:0]        minute_in;
    logic [NCH*SW-1:0]        second_in;
    logic [HW-1:0]            hour_display;
    logic [MW-1:0]            minute_display;
    logic [SW-1:0]            second_display;
    logic [2:0]               blank;
    logic [$clog2(NCH)-1:0]   active_ch;
    logic                     timeout_evt;

    modport master (
        output tick, req, edit_field, hour_in, minute_in, second_in,
        input  hour_display, minute_display, second_display, blank, active_ch, timeout_evt
    );

    modport slave (
        input  tick, req, edit_field, hour_in, minute_in, second_in,
        output hour_display, minute_display, second_display, blank, active_ch, timeout_evt
    );

endinterface
`default_nettype wire

// File: rtl/disp_src_sel_blink_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | blink_gen : tick-driven blink phase, toggles every BLINK_TICKS ticks  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module blink_gen #(
    parameter int BLINK_TICKS = 1
) (
    input  wire logic signal,
    input  wire logic rst_n,
    input  wire logic tick,
    input  wire logic clr,
    input  wire logic en,
    output logic      phase
);
    localparam int            CW   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_TICKS - 1);

    logic [CW-1:0] cnt;

    // clr wins over a coincident tick so a restart always begins visible
    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (en && tick) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt   <= cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/disp_src_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | disp_src_sel : display source selector with hold-off and field blink  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module disp_src_sel
    import disp_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int HW          = DEF_HW,
    parameter int MW          = DEF_MW,
    parameter int SW          = DEF_SW,
    parameter int HOLD_TICKS  = 5,
    parameter int BLINK_TICKS = 1
) (
    input  wire logic      signal,
    input  wire logic      rst_n,
    disp_src_sel_if.slave  bus
);
    localparam int             CHW       = $clog2(NCH);
    localparam int             HCW       = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

    state_t          state, state_nx;
    logic [CHW-1:0]  active_ch_q, ach_nx;
    logic [HCW-1:0]  hold_cnt, hold_nx;
    logic            evt_q, evt_nx;
    logic [1:0]      edit_q;
    logic [HW-1:0]   hour_q;
    logic [MW-1:0]   minute_q;
    logic [SW-1:0]   second_q;

    logic            req_any, req_multi;
    logic [CHW-1:0]  req_ch;
    logic            req_valid;
    logic            unused_req0;

    assign unused_req0 = bus.req[0];

    always_comb begin
        req_any   = 1'b0;
        req_multi = 1'b0;
        req_ch    = '0;
        for (int i = 1; i < NCH; i++) begin
            if (bus.req[i]) begin
                if (req_any) req_multi = 1'b1;
                req_any = 1'b1;
                req_ch  = i[CHW-1:0];
            end
        end
    end

    assign req_valid = req_any && !req_multi;

    always_comb begin
        state_nx = state;
        ach_nx   = active_ch_q;
        hold_nx  = hold_cnt;
        evt_nx   = 1'b0;
        if (req_multi) begin
            state_nx = LIVE;
            ach_nx   = '0;
            hold_nx  = '0;
        end else begin
            case (state)
                LIVE: begin
                    ach_nx  = '0;
                    hold_nx = '0;
                    if (req_valid) begin
                        state_nx = SHOW;
                        ach_nx   = req_ch;
                    end
                end
                SHOW: begin
                    hold_nx = '0;
                    if (req_valid) begin
                        ach_nx = req_ch;
                    end else if (HOLD_TICKS == 0) begin
                        state_nx = LIVE;
                        ach_nx   = '0;
                    end else begin
                        state_nx = HOLD;
                    end
                end
                HOLD: begin
                    if (req_valid) begin
                        state_nx = SHOW;
                        ach_nx   = req_ch;
                        hold_nx  = '0;
                    end else if (bus.tick) begin
                        // expiry compares before the increment, so the counter never passes HOLD_TICKS
                        if (hold_cnt >= HOLD_LAST) begin
                            state_nx = LIVE;
                            ach_nx   = '0;
                            hold_nx  = '0;
                            evt_nx   = 1'b1;
                        end else begin
                            hold_nx  = hold_cnt + HCW'(1);
                        end
                    end
                end
                default: begin
                    state_nx = LIVE;
                    ach_nx   = '0;
                    hold_nx  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LIVE;
            active_ch_q <= '0;
            hold_cnt    <= '0;
            evt_q       <= 1'b0;
            edit_q      <= FLD_NONE;
        end else begin
            state       <= state_nx;
            active_ch_q <= ach_nx;
            hold_cnt    <= hold_nx;
            evt_q       <= evt_nx;
            edit_q      <= bus.edit_field;
        end
    end

    logic [HW-1:0] hour_arr   [NCH];
    logic [MW-1:0] minute_arr [NCH];
    logic [SW-1:0] second_arr [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_unpack
        assign hour_arr[g]   = bus.hour_in[g*HW +: HW];
        assign minute_arr[g] = bus.minute_in[g*MW +: MW];
        assign second_arr[g] = bus.second_in[g*SW +: SW];
    end

    always_ff @(posedge signal or negedge rst_n) begin
        if (!rst_n) begin
            hour_q   <= '0;
            minute_q <= '0;
            second_q <= '0;
        end else begin
            hour_q   <= hour_arr[ach_nx];
            minute_q <= minute_arr[ach_nx];
            second_q <= second_arr[ach_nx];
        end
    end

    logic blink_en, blink_clr, phase;
    logic [2:0] blank_w;

    assign blink_en  = (bus.edit_field != FLD_NONE) && (ach_nx != '0);
    assign blink_clr = !blink_en || (ach_nx != active_ch_q) || (bus.edit_field != edit_q);

    blink_gen #(
        .BLINK_TICKS (BLINK_TICKS)
    ) u_blink (
        .signal (signal),
        .rst_n  (rst_n),
        .tick   (bus.tick),
        .clr    (blink_clr),
        .en     (blink_en),
        .phase  (phase)
    );

    // phase is held at 0 unless blink was active for the sampled edit field
    always_comb begin
        blank_w = 3'b000;
        if (phase) begin
            case (edit_q)
                FLD_HOUR: blank_w = 3'b100;
                FLD_MIN:  blank_w = 3'b010;
                FLD_SEC:  blank_w = 3'b001;
                default:  blank_w = 3'b000;
            endcase
        end
    end

    assign bus.hour_display   = hour_q;
    assign bus.minute_display = minute_q;
    assign bus.second_display = second_q;
    assign bus.blank          = blank_w;
    assign bus.active_ch      = active_ch_q;
    assign bus.timeout_evt    = evt_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_src_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_disp_src_sel : directed bench with a behavioural reference model   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_disp_src_sel;
    import disp_pkg::*;

    localparam int NCH         = 3;
    localparam int HW          = 5;
    localparam int MW          = 6;
    localparam int SW          = 6;
    localparam int HOLD_TICKS  = 2;
    localparam int BLINK_TICKS = 1;

    logic clk;
    logic rst_n;

    disp_src_sel_if #(.NCH(NCH), .HW(HW), .MW(MW), .SW(SW)) bus ();

    disp_src_sel #(
        .NCH         (NCH),
        .HW          (HW),
        .MW          (MW),
        .SW          (SW),
        .HOLD_TICKS  (HOLD_TICKS),
        .BLINK_TICKS (BLINK_TICKS)
    ) dut (
        .signal (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: shown channel, release tracking, ticks since blink restart
    int         m_ch;
    bit         m_rel;
    int         m_relt;
    int         m_bt;
    logic [1:0] m_edit;
    logic [HW-1:0] exp_h;
    logic [MW-1:0] exp_m;
    logic [SW-1:0] exp_s;
    logic [2:0]    exp_blank;
    logic          exp_evt;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", nm, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_ch = 0; m_rel = 0; m_relt = 0; m_bt = 0; m_edit = 2'd0;
        exp_h = '0; exp_m = '0; exp_s = '0; exp_blank = 3'b000; exp_evt = 1'b0;
    endtask

    task automatic model_step();
        int n_req = 0;
        int k = 0;
        int new_ch;
        bit active;
        for (int i = 1; i < NCH; i++) begin
            if (bus.req[i]) begin
                n_req++;
                k = i;
            end
        end
        new_ch  = m_ch;
        exp_evt = 1'b0;
        if (n_req > 1) begin
            new_ch = 0; m_rel = 0;
        end else if (n_req == 1) begin
            new_ch = k; m_rel = 0;
        end else if (m_ch != 0) begin
            if (!m_rel) begin
                if (HOLD_TICKS == 0) new_ch = 0;
                else begin m_rel = 1; m_relt = 0; end
            end else if (bus.tick) begin
                m_relt++;
                if (m_relt == HOLD_TICKS) begin
                    new_ch = 0; m_rel = 0; exp_evt = 1'b1;
                end
            end
        end
        active = (bus.edit_field != 2'd0) && (new_ch != 0);
        if (!active || new_ch != m_ch || bus.edit_field != m_edit) m_bt = 0;
        else if (bus.tick) m_bt++;
        exp_blank = 3'b000;
        if (((m_bt / BLINK_TICKS) % 2) == 1)
            exp_blank = 3'b100 >> (bus.edit_field - 2'd1);
        exp_h  = bus.hour_in[new_ch*HW +: HW];
        exp_m  = bus.minute_in[new_ch*MW +: MW];
        exp_s  = bus.second_in[new_ch*SW +: SW];
        m_ch   = new_ch;
        m_edit = bus.edit_field;
    endtask

    task automatic compare_model();
        chk("hour",   32'(bus.hour_display),   32'(exp_h));
        chk("minute", 32'(bus.minute_display), 32'(exp_m));
        chk("second", 32'(bus.second_display), 32'(exp_s));
        chk("blank",  32'(bus.blank),          32'(exp_blank));
        chk("active_ch", 32'(bus.active_ch),   32'(m_ch));
        chk("timeout_evt", 32'(bus.timeout_evt), 32'(exp_evt));
    endtask

    task automatic cyc(input logic t, input logic [2:0] r, input logic [1:0] e);
        bus.tick = t; bus.req = r; bus.edit_field = e;
        model_step();
        @(posedge clk); #1;
        compare_model();
    endtask

    task automatic lit_time(input string nm, input int h, input int m, input int s);
        chk({nm, "_h"}, 32'(bus.hour_display),   h);
        chk({nm, "_m"}, 32'(bus.minute_display), m);
        chk({nm, "_s"}, 32'(bus.second_display), s);
    endtask

    task automatic lit_reset_state(input string nm);
        lit_time(nm, 0, 0, 0);
        chk({nm, "_blank"}, 32'(bus.blank), 0);
        chk({nm, "_ach"},   32'(bus.active_ch), 0);
        chk({nm, "_evt"},   32'(bus.timeout_evt), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.tick = 1'b0; bus.req = '0; bus.edit_field = 2'd0;
        bus.hour_in   = {5'd7,  5'd0, 5'd12};
        bus.minute_in = {6'd30, 6'd1, 6'd34};
        bus.second_in = {6'd0,  6'd2, 6'd56};
        model_reset();
        repeat (2) @(posedge clk);
        #1 lit_reset_state("rst_init");
        rst_n = 1'b1;

        cyc(0, 3'b000, 0); lit_time("live", 12, 34, 56);
        cyc(0, 3'b001, 0); chk("req0_ignored", 32'(bus.active_ch), 0);

        // select, then conflict
        cyc(0, 3'b010, 0); lit_time("sel1", 0, 1, 2); chk("sel1_ach", 32'(bus.active_ch), 1);
        cyc(0, 3'b110, 0); lit_time("conf", 12, 34, 56); chk("conf_ach", 32'(bus.active_ch), 0);
        cyc(0, 3'b000, 0);

        // hold-off timeout
        cyc(0, 3'b100, 0); lit_time("sel2", 7, 30, 0);
        cyc(0, 3'b000, 0); chk("hold_ach", 32'(bus.active_ch), 2);
        cyc(1, 3'b000, 0); lit_time("hold_t1", 7, 30, 0); chk("hold_t1_evt", 32'(bus.timeout_evt), 0);
        cyc(0, 3'b000, 0);
        cyc(1, 3'b000, 0); lit_time("tmo", 12, 34, 56); chk("tmo_evt", 32'(bus.timeout_evt), 1);
        cyc(0, 3'b000, 0); chk("tmo_evt_gone", 32'(bus.timeout_evt), 0);

        // re-request in HOLD clears the hold count
        cyc(0, 3'b100, 0);
        cyc(0, 3'b000, 0);
        cyc(1, 3'b000, 0);
        cyc(0, 3'b010, 0); lit_time("rereq", 0, 1, 2);
        cyc(0, 3'b000, 0);
        cyc(1, 3'b000, 0); chk("rereq_t1_ach", 32'(bus.active_ch), 1);
        cyc(1, 3'b000, 0); chk("rereq_t2_ach", 32'(bus.active_ch), 0);
        chk("rereq_t2_evt", 32'(bus.timeout_evt), 1);

        // request beats a coincident tick at expiry
        cyc(0, 3'b100, 0);
        cyc(0, 3'b000, 0);
        cyc(1, 3'b000, 0);
        cyc(1, 3'b100, 0); chk("prio_ach", 32'(bus.active_ch), 2); chk("prio_evt", 32'(bus.timeout_evt), 0);
        cyc(0, 3'b000, 0);
        cyc(1, 3'b000, 0);
        cyc(1, 3'b000, 0);

        // blink on minute, then switch to second
        cyc(0, 3'b100, 2); chk("blk0", 32'(bus.blank), 32'b000);
        cyc(1, 3'b100, 2); chk("blk1", 32'(bus.blank), 32'b010);
        cyc(1, 3'b100, 2); chk("blk2", 32'(bus.blank), 32'b000);
        cyc(1, 3'b100, 2); chk("blk3", 32'(bus.blank), 32'b010);
        cyc(0, 3'b100, 2); chk("blk_notick", 32'(bus.blank), 32'b010);
        cyc(0, 3'b100, 3); chk("blk_sec0", 32'(bus.blank), 32'b000);
        cyc(1, 3'b100, 3); chk("blk_sec1", 32'(bus.blank), 32'b001);
        cyc(1, 3'b110, 3); chk("blk_conf", 32'(bus.blank), 32'b000);

        // blink suppressed on live time
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3'b000, 1); chk("blk_live", 32'(bus.blank), 32'b000);
        end

        // hour blink on channel 1, and data update under a stable selection
        cyc(0, 3'b010, 1); chk("blk_h0", 32'(bus.blank), 32'b000);
        cyc(1, 3'b010, 1); chk("blk_h1", 32'(bus.blank), 32'b100);
        bus.hour_in = {5'd7, 5'd9, 5'd12};
        cyc(0, 3'b010, 1); chk("data_upd", 32'(bus.hour_display), 9);

        // asynchronous reset mid-blink
        #2 rst_n = 1'b0;
        model_reset();
        #1 lit_reset_state("rst_mid");
        @(posedge clk); #1 lit_reset_state("rst_hold");
        compare_model();
        rst_n = 1'b1;
        cyc(0, 3'b010, 1); chk("post_rst_blank", 32'(bus.blank), 32'b000);
        chk("post_rst_ach", 32'(bus.active_ch), 1);
        cyc(1, 3'b010, 1); chk("post_rst_blk", 32'(bus.blank), 32'b100);
        cyc(0, 3'b000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/disp_src_sel.md
# disp_src_sel

Parametrised display-source selector for the electronic clock: chooses which of `NCH` time sources (channel 0 = live time, others = stopwatch, alarm, etc.) drives the 7-segment display path. Two additions over a plain multiplexer:
- a hold-off timer returns the display to live time after a request drops;
- a per-field blink mask marks the field being edited.

It sits between the time/stopwatch/alarm counters and the display decoder.

## Interface
- `NCH`, 3: number of sources, at least 2; channel 0 is live time.
- `HW`, 5: hour field width.
- `MW`, 6: minute field width.
- `SW`, 6: second field width.
- `HOLD_TICKS`, 5: ticks to stay on a released channel before returning to 0; 0 means return immediately.
- `BLINK_TICKS`, 1: ticks per blink half-period, at least 1.

Ports:
- `signal` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle timing enable.
- `req` in NCH: level requests; bit k asks for channel k; bit 0 is ignored.
- `edit_field` in 2: field being edited; 0 = none, 1 = hour, 2 = minute, 3 = second.
- `hour_in` in NCH*HW: packed hours, channel k at bits [k*HW +: HW]. `minute_in` (NCH*MW) and `second_in` (NCH*SW) are packed the same way.
- `hour_display` out HW, `minute_display` out MW, `second_display` out SW: selected time, registered.
- `blank` out 3: blank mask, bit 2 = hour, bit 1 = minute, bit 0 = second.
- `active_ch` out $clog2(NCH): channel currently shown.
- `timeout_evt` out 1: one-cycle pulse when the hold timer expires.

## Operation
- FSM states: LIVE, SHOW, HOLD.
- The request decode is "valid" when exactly one of `req[NCH-1:1]` is set, giving channel k.
- The decode is a "conflict" when two or more of those bits are set. A conflict forces LIVE immediately from any state, and `active_ch` becomes 0.
- **LIVE**: valid k → SHOW with `active_ch` = k.
- **SHOW**: valid k' different from k → stay in SHOW with `active_ch` = k'.
- **SHOW**: no request → HOLD with `hold_cnt` = 0. If `HOLD_TICKS` = 0, go straight to LIVE instead and do not pulse `timeout_evt`.
- **HOLD**: valid k' (including the same k) → SHOW with `active_ch` = k' and `hold_cnt` cleared.
- **HOLD**, otherwise, on each `tick`: `hold_cnt` increments. When it reaches `HOLD_TICKS`, go to LIVE and pulse `timeout_evt`.
- A request has priority over a `tick` arriving in the same cycle.
- Data path: each display register loads field `active_ch_next` of its packed input every cycle. Values are passed through unmodified, with no range checking.
- Blink applies only when `edit_field` ≠ 0 and `active_ch_next` ≠ 0. The blink counter advances on `tick`, and the blink phase toggles every `BLINK_TICKS` ticks. The selected field's `blank` bit equals the phase; all other bits are 0.
- Blink counter and phase reset to 0 (visible) whenever `active_ch` changes, `edit_field` changes, or blink is inactive.

## Timing
- All state and outputs update on the rising edge of `signal`.
- Latency is one cycle: `req`, data, and `edit_field` sampled at edge n are visible after edge n.
- Live data changing under a stable selection also appears one cycle later.
- Reset values: all displays 0, `blank` = 3'b000, `active_ch` = 0, `timeout_evt` = 0, FSM = LIVE, `hold_cnt` = 0, blink counter and phase = 0.
- Reset asserted mid-HOLD or mid-blink takes effect immediately (asynchronous). After release, the first edge evaluates from LIVE.
- `hold_cnt` width is $clog2(HOLD_TICKS+1). The counter saturates and cannot wrap.
- The `timeout_evt` pulse is high for exactly one cycle, in the same cycle that `active_ch` returns to 0.

## Structure
- Package `disp_pkg` holds:
  - state enum {LIVE, SHOW, HOLD};
  - field codes FLD_NONE/HOUR/MIN/SEC;
  - default widths HW/MW/SW.
- One sub-module, `blink_gen`. Inputs: `signal`, `rst_n`, `tick`, `clr`, `en`. Output: `phase`. Parameter: `BLINK_TICKS`.
- FSM, hold counter, and output mux stay in the top level.

## Test plan
All scenarios use NCH=3, HOLD_TICKS=2, BLINK_TICKS=1. Channel 0 = 12:34:56, channel 1 = 00:01:02, channel 2 = 07:30:00.
- **Reset:** pulse `rst_n` low mid-stream → displays 00:00:00, `blank` = 000, `active_ch` = 0 during and after reset.
- **Select and conflict:** `req` = 3'b010 → 00:01:02 one cycle later. Then `req` = 3'b110 → 12:34:56 and `active_ch` = 0 the next cycle.
- **Hold-off timeout:** `req` = 3'b100 then 0 → 07:30:00 held through one tick. At the second tick → 12:34:56 and `timeout_evt` = 1 for one cycle.
- **Re-request in HOLD:** `req` drops, one tick, then `req` = 3'b010 → 00:01:02 and `hold_cnt` cleared. Two further ticks without the request are needed to return to live.
- **Blink:** `req` = 3'b100 held and `edit_field` = 2 → `blank` sequence 000, 010, 000, 010 on successive ticks. Changing `edit_field` to 3 → `blank` = 000 immediately, then 001 after the next tick.
- **Blink suppressed on live:** `req` = 0 and `edit_field` = 1, with ticks running → `blank` stays 000.
